// File: rtl/serial_dac_pkg.sv
// Shared types and helpers for the serial DAC transmitter.
package serial_dac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // aclk cycles from the accepting edge until s_ready rises again
    function automatic int frame_len(input int dw, input int clk_div, input int cs_gap);
        return clk_div * (2 * dw + 2) + cs_gap;
    endfunction

    localparam int DEF_CHAN_W = chan_w(2);

endpackage

// File: rtl/serial_dac_tx_sclk_tick_gen.sv
// Half-period tick generator: tick_o marks the last aclk cycle of every CLK_DIV-cycle slot.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNTW = $clog2(CLK_DIV + 1);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    assign tick_o = (cnt_q == CNTW'(CLK_DIV - 1));

    // Next count: reload on restart or at the end of each slot.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Slot counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_dac_tx.sv
// Multi-channel SPI-style DAC transmitter: one frame per accepted word, shared sclk/sdi/ldac_n.
module serial_dac_tx
    import serial_dac_pkg::*;
#(
    parameter  int DW        = 16,
    parameter  int NCH       = 2,
    parameter  int CLK_DIV   = 2,
    parameter  int MSB_FIRST = 1,
    parameter  int CS_GAP    = 2,
    localparam int CW        = chan_w(NCH)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          en,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [CW-1:0] s_chan,
    output logic          sclk,
    output logic          sdi,
    output logic [NCH-1:0] cs_n,
    output logic          ldac_n,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(DW + 1);
    localparam int GW = $clog2(CS_GAP + 1);

    state_e           state_q;
    logic             sclk_q;
    logic             sdi_q;
    logic [NCH-1:0]   cs_n_q;
    logic             ldac_n_q;
    logic             busy_q;
    logic             done_q;
    logic             high_q;
    logic [DW-1:0]    shreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [GW-1:0]    gap_cnt_q;

    logic             s_ready_s;
    logic             accept_s;
    logic             chan_ok_s;
    logic             first_bit_s;
    logic [NCH-1:0]   cs_sel_s;
    logic             tick_s;

    assign s_ready_s   = (state_q == IDLE) && en;
    assign accept_s    = s_valid && s_ready_s;
    assign chan_ok_s   = (int'(s_chan) < NCH);
    assign first_bit_s = (MSB_FIRST != 0) ? s_data[DW-1] : s_data[0];

    // Active-low select pattern for the requested channel.
    always_comb begin
        cs_sel_s = '1;
        for (int i = 0; i < NCH; i++) begin
            if (int'(s_chan) == i) begin
                cs_sel_s[i] = 1'b0;
            end else begin
                cs_sel_s[i] = 1'b1;
            end
        end
    end

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i     (aclk),
        .rst_i     (areset),
        .restart_i (state_q == IDLE),
        .tick_o    (tick_s)
    );

    // Frame sequencer with all pin-facing outputs registered.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            cs_n_q    <= '1;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            high_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            done_q   <= 1'b0;
            ldac_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // An out-of-range channel is consumed here without starting a frame.
                    if (accept_s && chan_ok_s) begin
                        state_q   <= SETUP;
                        busy_q    <= 1'b1;
                        cs_n_q    <= cs_sel_s;
                        sclk_q    <= 1'b0;
                        sdi_q     <= first_bit_s;
                        shreg_q   <= s_data;
                        bit_cnt_q <= '0;
                        high_q    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick_s) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        if (!high_q) begin
                            sclk_q <= 1'b1;
                            high_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            high_q <= 1'b0;
                            // sdi only moves together with the falling sclk edge.
                            if (bit_cnt_q == BW'(DW - 1)) begin
                                state_q <= HOLD;
                            end else if (MSB_FIRST != 0) begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                                sdi_q     <= shreg_q[DW-2];
                                shreg_q   <= {shreg_q[DW-2:0], 1'b0};
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                                sdi_q     <= shreg_q[1];
                                shreg_q   <= {1'b0, shreg_q[DW-1:1]};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick_s) begin
                        state_q   <= GAP;
                        cs_n_q    <= '1;
                        sdi_q     <= 1'b0;
                        ldac_n_q  <= 1'b0;
                        gap_cnt_q <= '0;
                        done_q    <= (CS_GAP == 1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(CS_GAP - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                        done_q    <= ((gap_cnt_q + GW'(1)) == GW'(CS_GAP - 1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= '1;
                    sclk_q  <= 1'b0;
                    sdi_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_s;
    assign sclk    = sclk_q;
    assign sdi     = sdi_q;
    assign cs_n    = cs_n_q;
    assign ldac_n  = ldac_n_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_dac_tx.sv
// Directed bench for serial_dac_tx: default instance checked through a frame scoreboard, second instance for LSB-first / invalid channel.
module tb_serial_dac_tx;
    import serial_dac_pkg::*;

    logic aclk;
    logic areset;

    logic        a_en, a_valid, a_ready, a_sclk, a_sdi, a_ldac_n, a_busy, a_done;
    logic [15:0] a_data;
    logic [0:0]  a_chan;
    logic [1:0]  a_cs_n;

    logic        b_en, b_valid, b_ready, b_sclk, b_sdi, b_ldac_n, b_busy, b_done;
    logic [11:0] b_data;
    logic [1:0]  b_chan;
    logic [2:0]  b_cs_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  cs;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int done_k;
        int done_cnt;
        int ldac_k;
        int ldac_cnt;
        int ready_k;
        int gap_busy;
        int cs_high;
    } obs_t;
    obs_t o;

    int both_low = 0;
    int cs_switch = 0;

    localparam int FRAME_A = frame_len(16, 2, 2);
    localparam int FRAME_B = frame_len(12, 3, 2);

    serial_dac_tx dut_a (
        .aclk    (aclk),
        .areset  (areset),
        .en      (a_en),
        .s_valid (a_valid),
        .s_ready (a_ready),
        .s_data  (a_data),
        .s_chan  (a_chan),
        .sclk    (a_sclk),
        .sdi     (a_sdi),
        .cs_n    (a_cs_n),
        .ldac_n  (a_ldac_n),
        .busy    (a_busy),
        .done    (a_done)
    );

    serial_dac_tx #(
        .DW        (12),
        .NCH       (3),
        .CLK_DIV   (3),
        .MSB_FIRST (0),
        .CS_GAP    (2)
    ) dut_b (
        .aclk    (aclk),
        .areset  (areset),
        .en      (b_en),
        .s_valid (b_valid),
        .s_ready (b_ready),
        .s_data  (b_data),
        .s_chan  (b_chan),
        .sclk    (b_sclk),
        .sdi     (b_sdi),
        .cs_n    (b_cs_n),
        .ldac_n  (b_ldac_n),
        .busy    (b_busy),
        .done    (b_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame monitor for dut_a: collects bits at each sclk rise, compares against the scoreboard when cs_n releases.
    initial begin : monitor_a
        logic [15:0] mon_bits;
        logic [1:0]  mon_cs;
        int          mon_nb, mon_low;
        bit          mon_on, mon_prev;
        exp_t        e;
        mon_on = 1'b0;
        mon_prev = 1'b0;
        mon_bits = '0;
        mon_cs = 2'b11;
        mon_nb = 0;
        mon_low = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                mon_on = 1'b0;
                mon_prev = 1'b0;
            end else begin
                if (a_cs_n == 2'b00) both_low++;
                if (a_cs_n != 2'b11) begin
                    if (!mon_on) begin
                        mon_on = 1'b1;
                        mon_bits = '0;
                        mon_nb = 0;
                        mon_low = 0;
                        mon_cs = a_cs_n;
                    end
                    mon_low++;
                    if (a_sclk && !mon_prev) begin
                        mon_bits = {mon_bits[14:0], a_sdi};
                        mon_nb++;
                    end
                    if (a_cs_n != mon_cs) cs_switch++;
                end else if (mon_on) begin
                    mon_on = 1'b0;
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("frame_bits", 32'(mon_bits), 32'(e.data));
                        chk("frame_cs", 32'(mon_cs), 32'(e.cs));
                        chk("frame_nbits", mon_nb, 16);
                        chk("frame_cs_low_cycles", mon_low, 68);
                    end
                end
                mon_prev = a_sclk;
            end
        end
    end

    // Observes dut_a for ncyc cycles starting one step after the accepting edge.
    task automatic observe_a(input int ncyc, input int en_drop_k, output obs_t r);
        r = '{-1, 0, -1, 0, -1, 0, 0};
        for (int k = 0; k < ncyc; k++) begin
            if (a_done) begin
                r.done_cnt++;
                if (r.done_k < 0) r.done_k = k;
            end
            if (!a_ldac_n) begin
                r.ldac_cnt++;
                if (r.ldac_k < 0) r.ldac_k = k;
            end
            if (a_ready && r.ready_k < 0) r.ready_k = k;
            if (a_cs_n == 2'b11) begin
                r.cs_high++;
                if (a_busy) r.gap_busy++;
            end
            if (k == en_drop_k) a_en = 1'b0;
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic frame_b(input string tag, input logic [11:0] word, input logic [1:0] chan,
                           input logic [2:0] exp_cs);
        logic [11:0] exp_bits;
        logic [11:0] bits;
        int nrise, nhigh, run, bad_run, done_k, ready_k, cs_bad;
        bit prev;
        for (int i = 0; i < 12; i++) exp_bits[11-i] = word[i];
        bits = '0;
        nrise = 0; nhigh = 0; run = 0; bad_run = 0; done_k = -1; ready_k = -1; cs_bad = 0;
        prev = 1'b0;
        b_valid = 1'b1;
        b_data = word;
        b_chan = chan;
        #1;
        chk({tag, "_ready_before"}, 32'(b_ready), 32'd1);
        @(posedge aclk);
        #1;
        b_valid = 1'b0;
        for (int k = 0; k < FRAME_B + 5; k++) begin
            if (b_sclk && !prev) begin
                bits = {bits[10:0], b_sdi};
                nrise++;
            end
            if (b_sclk) begin
                nhigh++;
                run++;
            end else begin
                if (run != 0 && run != 3) bad_run++;
                run = 0;
            end
            prev = b_sclk;
            if (b_done && done_k < 0) done_k = k;
            if (b_ready && ready_k < 0) ready_k = k;
            if (k < FRAME_B - 2 && b_cs_n != exp_cs) cs_bad++;
            if (k >= FRAME_B - 2 && b_cs_n != 3'b111) cs_bad++;
            @(posedge aclk);
            #1;
        end
        chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        chk({tag, "_rises"}, nrise, 12);
        chk({tag, "_sclk_high_cycles"}, nhigh, 36);
        chk({tag, "_bad_half_periods"}, bad_run, 0);
        chk({tag, "_cs_pattern"}, cs_bad, 0);
        chk({tag, "_done_k"}, done_k, FRAME_B - 1);
        chk({tag, "_ready_k"}, ready_k, FRAME_B);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int bad_cs, n_done, n_notready, n_busy;
        areset = 1'b1;
        a_en = 1'b1; a_valid = 1'b0; a_data = '0; a_chan = '0;
        b_en = 1'b1; b_valid = 1'b0; b_data = '0; b_chan = '0;
        repeat (3) @(negedge aclk);

        // Reset state
        chk("rst_cs_n", 32'(a_cs_n), 32'h3);
        chk("rst_sclk_sdi", 32'({a_sclk, a_sdi}), 32'h0);
        chk("rst_ldac_busy_done", 32'({a_ldac_n, a_busy, a_done}), 32'h4);
        chk("rst_b_cs_n", 32'(b_cs_n), 32'h7);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // 1: single frame on channel 0
        chk("t1_ready_idle", 32'(a_ready), 32'd1);
        a_valid = 1'b1; a_data = 16'hA5C3; a_chan = 1'b0;
        sbq.push_back('{16'hA5C3, 2'b10});
        @(posedge aclk);
        #1;
        a_valid = 1'b0;
        chk("t1_busy_k0", 32'(a_busy), 32'd1);
        observe_a(FRAME_A + 1, -1, o);
        chk("t1_done_k", o.done_k, FRAME_A - 1);
        chk("t1_done_cnt", o.done_cnt, 1);
        chk("t1_ldac_k", o.ldac_k, FRAME_A - 2);
        chk("t1_ldac_cnt", o.ldac_cnt, 1);
        chk("t1_ready_k", o.ready_k, FRAME_A);

        // 2: back-to-back frames, channel 1 then channel 0
        a_valid = 1'b1; a_data = 16'h0001; a_chan = 1'b1;
        sbq.push_back('{16'h0001, 2'b01});
        sbq.push_back('{16'h8000, 2'b10});
        @(posedge aclk);
        #1;
        a_data = 16'h8000; a_chan = 1'b0;
        observe_a(FRAME_A + 1, -1, o);
        chk("t2_ready_k", o.ready_k, FRAME_A);
        chk("t2_gap_busy_cycles", o.gap_busy, 2);
        chk("t2_cs_high_between", o.cs_high, 3);
        chk("t2_second_cs", 32'(a_cs_n), 32'h2);
        a_valid = 1'b0;
        observe_a(FRAME_A + 1, -1, o);
        chk("t2_done_k", o.done_k, FRAME_A - 1);
        chk("t2_both_low", both_low, 0);

        // 6: enable dropped mid-frame
        a_valid = 1'b1; a_data = 16'h5A3C; a_chan = 1'b1;
        sbq.push_back('{16'h5A3C, 2'b01});
        @(posedge aclk);
        #1;
        a_data = 16'h0F0F; a_chan = 1'b0;
        observe_a(FRAME_A + 5, 10, o);
        chk("t6_done_k", o.done_k, FRAME_A - 1);
        chk("t6_no_ready", o.ready_k, -1);
        chk("t6_idle_busy", 32'(a_busy), 32'd0);
        a_en = 1'b1;
        #1;
        chk("t6_ready_on_en", 32'(a_ready), 32'd1);
        sbq.push_back('{16'h0F0F, 2'b10});
        @(posedge aclk);
        #1;
        a_valid = 1'b0;
        chk("t6_handshake", 32'({a_busy, a_cs_n}), 32'h6);
        observe_a(FRAME_A + 1, -1, o);
        chk("t6_done_k2", o.done_k, FRAME_A - 1);

        // 5: reset in the middle of a frame
        a_valid = 1'b1; a_data = 16'h1234; a_chan = 1'b0;
        sbq.push_back('{16'h1234, 2'b10});
        @(posedge aclk);
        #1;
        a_valid = 1'b0;
        repeat (20) begin
            @(posedge aclk);
            #1;
        end
        chk("t5_pre_busy", 32'(a_busy), 32'd1);
        areset = 1'b1;
        #1;
        chk("t5_cs_n", 32'(a_cs_n), 32'h3);
        chk("t5_sclk", 32'(a_sclk), 32'd0);
        chk("t5_ldac_busy", 32'({a_ldac_n, a_busy, a_done}), 32'h4);
        sbq.delete();
        @(negedge aclk);
        @(posedge aclk);
        #2;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        a_valid = 1'b1; a_data = 16'hC3A5; a_chan = 1'b1;
        sbq.push_back('{16'hC3A5, 2'b01});
        @(posedge aclk);
        #1;
        a_valid = 1'b0;
        observe_a(FRAME_A + 1, -1, o);
        chk("t5_done_k", o.done_k, FRAME_A - 1);
        chk("t5_ldac_cnt", o.ldac_cnt, 1);
        chk("sb_drained", sbq.size(), 0);
        chk("cs_switch_in_frame", cs_switch, 0);

        // 3: LSB first, DW=12, CLK_DIV=3
        frame_b("t3a", 12'h801, 2'd0, 3'b110);
        frame_b("t3b", 12'h123, 2'd2, 3'b011);

        // 4: out-of-range channel is swallowed
        b_valid = 1'b1; b_data = 12'hFFF; b_chan = 2'd3;
        #1;
        chk("t4_ready", 32'(b_ready), 32'd1);
        @(posedge aclk);
        #1;
        b_valid = 1'b0;
        bad_cs = 0; n_done = 0; n_notready = 0; n_busy = 0;
        for (int k = 0; k < 12; k++) begin
            if (b_cs_n != 3'b111) bad_cs++;
            if (b_done) n_done++;
            if (!b_ready) n_notready++;
            if (b_busy) n_busy++;
            @(posedge aclk);
            #1;
        end
        chk("t4_cs_low", bad_cs, 0);
        chk("t4_done", n_done, 0);
        chk("t4_ready_drop", n_notready, 0);
        chk("t4_busy", n_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
